// File: rtl/bus_arbiter_if.sv
// Bus between the masters and the arbiter/slave side of the shared serial bus.
interface bus_arbiter_if #(
  parameter int unsigned NMasters = 2
) ();
  localparam int unsigned OwnerW = $clog2(NMasters);

  logic [NMasters-1:0] m_req;
  logic [NMasters-1:0] m_util;
  logic [NMasters-1:0] m_rw;
  logic [NMasters-1:0] m_bus_out;
  logic [NMasters-1:0] m_grant;
  logic                s_util;
  logic                s_rw;
  logic                s_bus;
  logic                arb_busy;
  logic [OwnerW-1:0]   arb_owner;
  logic                timeout_err;
  logic                proto_err;

  // Master side: drives requests and serial data, observes grant and status.
  modport master (
    output m_req, m_util, m_rw, m_bus_out,
    input  m_grant, s_util, s_rw, s_bus, arb_busy, arb_owner, timeout_err, proto_err
  );

  // Arbiter side: consumes master signals, produces grant, muxed bus and status.
  modport slave (
    input  m_req, m_util, m_rw, m_bus_out,
    output m_grant, s_util, s_rw, s_bus, arb_busy, arb_owner, timeout_err, proto_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with idle-grant timeout, protocol check and owner mux.
module bus_arbiter #(
  parameter int unsigned NMasters    = 2,
  parameter int unsigned IdleTimeout = 16
) (
  input logic          clk_i,
  input logic          rstn_i,  // active-high synchronous reset
  bus_arbiter_if.slave bus_io
);
  localparam int unsigned      OwnerW  = $clog2(NMasters);
  localparam int unsigned      TcntW   = $clog2(IdleTimeout + 1);
  localparam logic [TcntW-1:0] TcntMax = TcntW'(IdleTimeout - 1);

  typedef enum logic [1:0] {StIdle, StGrant, StActive, StRelease} state_e;

  state_e              state_q, state_d;
  logic [NMasters-1:0] grant_q, grant_d;
  logic                busy_q, busy_d;
  logic [OwnerW-1:0]   owner_q, owner_d;
  logic [OwnerW-1:0]   last_q, last_d;
  logic [TcntW-1:0]    tcnt_q, tcnt_d;
  logic                tout_q, tout_d;
  logic                perr_q, perr_d;

  logic [OwnerW-1:0]   sel;
  logic                sel_valid;
  logic                own_req, own_util, others_req, idle_expired;
  int unsigned         idx;

  assign own_req      = bus_io.m_req[owner_q];
  assign own_util     = bus_io.m_util[owner_q];
  assign others_req   = |(bus_io.m_req & ~grant_q);
  assign idle_expired = (tcnt_q == TcntMax);

  // Round-robin pick: first requester scanning upward from the most recent owner.
  always_comb begin
    sel       = last_q;
    sel_valid = 1'b0;
    idx       = 0;
    for (int unsigned k = 1; k <= NMasters; k++) begin
      idx = (32'(last_q) + k) % NMasters;
      if (!sel_valid && bus_io.m_req[OwnerW'(idx)]) begin
        sel       = OwnerW'(idx);
        sel_valid = 1'b1;
      end
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rstn_i) begin
      state_q <= StIdle;
      grant_q <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
      last_q  <= OwnerW'(NMasters - 1);
      tcnt_q  <= '0;
      tout_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      tcnt_q  <= tcnt_d;
      tout_q  <= tout_d;
      perr_q  <= perr_d;
    end
  end

  // Next-state logic; first UTIL beats both release causes and the timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StRelease: state_d = sel_valid ? StGrant : StIdle;
      StGrant: begin
        if (own_util)                       state_d = StActive;
        else if (!own_req)                  state_d = StRelease;
        else if (idle_expired && others_req) state_d = StRelease;
      end
      StActive: if (!own_req) state_d = StRelease;
      default: state_d = StIdle;
    endcase
  end

  // Next values of grant, owner, pointer, idle counter and error pulses.
  always_comb begin
    grant_d = grant_q;
    busy_d  = busy_q;
    owner_d = owner_q;
    last_d  = last_q;
    tcnt_d  = tcnt_q;
    tout_d  = 1'b0;
    // Any UTIL from a master not holding the grant is a violation.
    perr_d  = |(bus_io.m_util & ~grant_q);
    unique case (state_q)
      StIdle, StRelease: begin
        if (sel_valid) begin
          grant_d      = '0;
          grant_d[sel] = 1'b1;
          busy_d       = 1'b1;
          owner_d      = sel;
          last_d       = sel;
          tcnt_d       = '0;
        end
      end
      StGrant: begin
        if (state_d == StRelease) begin
          grant_d = '0;
          busy_d  = 1'b0;
          // Owner still requesting means the release came from the timeout.
          tout_d  = own_req;
        end else if (!own_util && !idle_expired) begin
          tcnt_d = tcnt_q + TcntW'(1);
        end
      end
      StActive: begin
        if (state_d == StRelease) begin
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign bus_io.m_grant     = grant_q;
  assign bus_io.arb_busy    = busy_q;
  assign bus_io.arb_owner   = owner_q;
  assign bus_io.timeout_err = tout_q;
  assign bus_io.proto_err   = perr_q;
  assign bus_io.s_util      = busy_q & own_util;
  assign bus_io.s_rw        = busy_q & bus_io.m_rw[owner_q];
  assign bus_io.s_bus       = busy_q & bus_io.m_bus_out[owner_q];
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: behavioural owner/round-robin model plus directed literal checks.
module tb_bus_arbiter;
  localparam int N = 4;
  localparam int T = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] util = '0;
  logic [N-1:0] rw = '0;
  logic [N-1:0] bout = '0;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  bus_arbiter_if #(.NMasters(N)) bus ();

  assign bus.m_req     = req;
  assign bus.m_util    = util;
  assign bus.m_rw      = rw;
  assign bus.m_bus_out = bout;

  bus_arbiter #(.NMasters(N), .IdleTimeout(T)) dut (
    .clk_i (clk),
    .rstn_i(rst),
    .bus_io(bus)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Model: who owns the bus (-1 = nobody), whether the owner has used it, idle count.
  int mo = -1, mlast = N - 1, marb = 0, midle = 0;
  bit mused = 0, mtout = 0, mperr = 0;

  always @(posedge clk) begin
    int  o, last, arb, idle, pick, c;
    bit  used, tout, perr, others;
    if (rst) begin
      mo <= -1; mlast <= N - 1; marb <= 0; midle <= 0;
      mused <= 0; mtout <= 0; mperr <= 0;
    end else begin
      perr = 0;
      for (int i = 0; i < N; i++) if (util[i] && i != mo) perr = 1;
      o = mo; last = mlast; arb = marb; idle = midle; used = mused; tout = 0;
      if (o < 0) begin
        pick = -1;
        for (int k = 1; k <= N; k++) begin
          c = (last + k) % N;
          if (pick < 0 && req[c]) pick = c;
        end
        if (pick >= 0) begin
          o = pick; last = pick; arb = pick; used = 0; idle = 0;
        end
      end else if (!used) begin
        others = 0;
        for (int i = 0; i < N; i++) if (i != o && req[i]) others = 1;
        if (util[o]) used = 1;
        else if (!req[o]) o = -1;
        else if (idle == T - 1 && others) begin o = -1; tout = 1; end
        else if (idle < T - 1) idle++;
      end else if (!req[o]) begin
        o = -1;
      end
      mo <= o; mlast <= last; marb <= arb; midle <= idle;
      mused <= used; mtout <= tout; mperr <= perr;
    end
  end

  // Compare every output against the model each cycle, away from the clock edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_grant", int'(bus.m_grant), (mo >= 0) ? (1 << mo) : 0);
      chk("arb_busy", int'(bus.arb_busy), int'(mo >= 0));
      chk("arb_owner", int'(bus.arb_owner), marb);
      chk("timeout_err", int'(bus.timeout_err), int'(mtout));
      chk("proto_err", int'(bus.proto_err), int'(mperr));
      chk("s_util", int'(bus.s_util), (mo >= 0) ? int'(util[mo]) : 0);
      chk("s_rw", int'(bus.s_rw), (mo >= 0) ? int'(rw[mo]) : 0);
      chk("s_bus", int'(bus.s_bus), (mo >= 0) ? int'(bout[mo]) : 0);
    end
  end

  logic [15:0] addr;
  logic [7:0]  data;
  int          rr_exp[5];
  bit          u, b;

  initial begin
    addr = 16'hA5C3;
    data = 8'h96;
    rr_exp = '{0, 1, 2, 3, 0};

    // Reset state.
    rst = 1'b1;
    step(2);
    cmp_en = 1'b1;
    chk("rst_grant", int'(bus.m_grant), 0);
    chk("rst_busy", int'(bus.arb_busy), 0);
    chk("rst_owner", int'(bus.arb_owner), 0);
    rst = 1'b0;

    // Both request: master 0 first, one dead cycle, then master 1.
    req = 4'b0011;
    step(1);
    chk("first_grant", int'(bus.m_grant), 1);
    chk("first_owner", int'(bus.arb_owner), 0);
    req = 4'b0010;
    step(1);
    chk("handover_dead", int'(bus.m_grant), 0);
    step(1);
    chk("handover_grant", int'(bus.m_grant), 2);
    chk("handover_owner", int'(bus.arb_owner), 1);
    req = 4'b0000;
    step(2);

    // Master 0 transfer: 16 address bits, 3-cycle ACK gap, 8 data bits; master 1 waits.
    req = 4'b0011;
    step(1);
    chk("xfer_grant", int'(bus.m_grant), 1);
    for (int i = 0; i < 27; i++) begin
      if (i < 16) begin
        u = 1'b1; b = addr[15-i];
      end else if (i < 19) begin
        u = 1'b0; b = 1'b0;
      end else begin
        u = 1'b1; b = data[26-i];
      end
      util = {3'b000, u};
      bout = {2'b00, ~b, b};
      rw   = 4'b0001;
      #1;
      chk("stream_s_bus", int'(bus.s_bus), int'(b));
      step(1);
    end
    chk("xfer_held", int'(bus.m_grant), 1);
    util = '0; bout = '0; rw = '0; req = '0;
    step(2);

    // Timeout: master 0 granted but silent while master 1 requests.
    req = 4'b0001;
    step(1);
    req = 4'b0011;
    step(15);
    chk("to_still_held", int'(bus.m_grant), 1);
    step(1);
    chk("to_dropped", int'(bus.m_grant), 0);
    chk("to_err", int'(bus.timeout_err), 1);
    step(1);
    chk("to_next_grant", int'(bus.m_grant), 2);
    chk("to_err_pulse", int'(bus.timeout_err), 0);
    req = 4'b0001;
    step(2);
    chk("to_regrant0", int'(bus.m_grant), 1);

    // Single requester idle for 100 cycles keeps the grant.
    step(100);
    chk("lone_held", int'(bus.m_grant), 1);

    // Master 1 drives UTIL while master 0 owns.
    util = 4'b0010;
    #1;
    chk("proto_s_util", int'(bus.s_util), 0);
    step(1);
    chk("proto_err", int'(bus.proto_err), 1);
    util = 4'b0000;
    step(1);
    chk("proto_err_pulse", int'(bus.proto_err), 0);

    // Reset while master 0 is active.
    util = 4'b0001;
    step(1);
    rst = 1'b1;
    step(1);
    chk("midrst_grant", int'(bus.m_grant), 0);
    chk("midrst_busy", int'(bus.arb_busy), 0);
    rst = 1'b0; util = '0;

    // All four request; each owner releases after 5 cycles.
    req = 4'b1111;
    step(1);
    for (int i = 0; i < 5; i++) begin
      chk("rr_owner", int'(bus.arb_owner), rr_exp[i]);
      chk("rr_grant", int'(bus.m_grant), 1 << rr_exp[i]);
      step(4);
      req[rr_exp[i]] = 1'b0;
      step(1);
      chk("rr_dead", int'(bus.m_grant), 0);
      req = 4'b1111;
      step(1);
    end

    req = '0;
    step(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter and bus multiplexer for the shared serial bus. Sits between up to N bus masters (each driving B_REQ/B_UTIL/B_RW/B_BUS_OUT and receiving B_GRANT) and the slave side of the bus. It issues a one-hot grant, holds it for the owner's whole transaction, and steers the owner's serial outputs onto the shared slave lines. It also revokes grants that are never used while others wait, and flags protocol violations.

## Interface
- N_MASTERS, 2: number of requesting masters, 2..8.
- IDLE_TIMEOUT, 16: cycles a granted but unused bus may stay with one master while another requests, ≥2.

- CLK  in  1  clock; all state updates on rising edge.
- RSTN  in  1  synchronous, active-high reset (sampled on rising CLK; high = reset).
- M_REQ  in  N_MASTERS  per-master bus request (master's B_REQ).
- M_UTIL  in  N_MASTERS  per-master bus-utilisation strobe (master's B_UTIL).
- M_RW  in  N_MASTERS  per-master direction (1 = write, 0 = read).
- M_BUS_OUT  in  N_MASTERS  per-master serial data out.
- M_GRANT  out  N_MASTERS  one-hot grant (master's B_GRANT); registered.
- S_UTIL  out  1  owner's M_UTIL to slaves; 0 when no grant.
- S_RW  out  1  owner's M_RW; 0 when no grant.
- S_BUS  out  1  owner's M_BUS_OUT; 0 when no grant.
- ARB_BUSY  out  1  high while any grant is asserted; registered.
- ARB_OWNER  out  clog2(N_MASTERS)  index of current owner, or last owner when idle; registered.
- TIMEOUT_ERR  out  1  one-cycle pulse when a grant is revoked by timeout.
- PROTO_ERR  out  1  one-cycle pulse, registered: a non-granted master asserted M_UTIL.

## Operation
- States: IDLE, GRANT (granted, no M_UTIL seen yet), ACTIVE (owner has asserted M_UTIL at least once), RELEASE (one dead cycle; all grants low).
- Round-robin pointer LAST = index of the most recent owner. Reset value is N_MASTERS-1, so master 0 wins first.
- Selection: the first requester scanning LAST+1, LAST+2, … modulo N_MASTERS.
- IDLE: if any M_REQ is high, go to GRANT, set M_GRANT one-hot for the selected master, and set ARB_OWNER = LAST = selected.
- GRANT:
  - M_UTIL[owner] = 1 → ACTIVE.
  - M_REQ[owner] = 0 → RELEASE.
  - Timeout: idle counter TCNT (width clog2(IDLE_TIMEOUT+1)) is cleared on GRANT entry and increments each GRANT cycle with M_UTIL[owner] = 0. If TCNT == IDLE_TIMEOUT-1 and any other M_REQ is high → RELEASE, with TIMEOUT_ERR pulsing in the RELEASE cycle.
  - With no other requester, TCNT saturates at IDLE_TIMEOUT-1 and the grant is kept.
- ACTIVE: the grant is never revoked; M_UTIL gaps during ACK phases are legal. M_REQ[owner] = 0 → RELEASE.
- Priority within GRANT: an M_UTIL rising edge beats timeout in the same cycle, so the state goes to ACTIVE with no error.
- RELEASE: M_GRANT is all zero and ARB_BUSY = 0. Selection is evaluated this cycle from M_REQ with the updated LAST. Any request → GRANT next cycle; none → IDLE.
- A timed-out master still requesting stays eligible. It comes last in rotation because LAST equals its index.
- Mux outputs are combinational from the owner's inputs, ANDed with the registered ARB_BUSY.
- PROTO_ERR: registered OR over i ≠ owner of (M_UTIL[i] & ~M_GRANT[i]). When no grant is held, any M_UTIL counts. The offending UTIL is not forwarded.
- Reset values: state IDLE, M_GRANT 0, ARB_BUSY 0, ARB_OWNER 0, LAST N_MASTERS-1, TCNT 0, TIMEOUT_ERR 0, PROTO_ERR 0. S_* are therefore 0.
- Reset mid-transaction drops the grant next edge; no RELEASE cycle.

## Timing
- Grant latency from IDLE: M_REQ high sampled at edge t → M_GRANT high after edge t (visible cycle t+1).
- Handover: owner M_REQ low sampled at edge t → grants low for one cycle (RELEASE) → new grant after edge t+1. Minimum 1 dead cycle between owners.
- Timeout: GRANT entered at edge g, no M_UTIL, other requester present → grant drops after edge g+IDLE_TIMEOUT. The next grant follows one edge later.
- S_UTIL/S_RW/S_BUS have zero-cycle latency from the owner's inputs while granted.
- Back-to-back: the same master re-requesting with no competitor after RELEASE is re-granted.

## Test plan
- Reset, then M_REQ = 2'b11 → M_GRANT = 2'b01 one cycle later, ARB_OWNER = 0. Master 0 drops REQ → one cycle of 2'b00, then 2'b10, ARB_OWNER = 1.
- Owner 0 runs 16 address bits + 3-cycle ACK gap + 8 data bits while M_REQ[1] = 1 → grant held throughout, no TIMEOUT_ERR. S_BUS matches the master-0 bit stream exactly.
- IDLE_TIMEOUT = 16: master 0 granted, never asserts M_UTIL, master 1 requesting → grant drops 16 cycles after grant, one-cycle TIMEOUT_ERR, master 1 granted the next cycle.
- Single requester idle for 100 cycles → grant held, no TIMEOUT_ERR.
- N_MASTERS = 4, all request continuously, each releases after 5 cycles → grant order 0,1,2,3,0.
- Master 1 asserts M_UTIL while master 0 owns → PROTO_ERR pulses one cycle later, S_UTIL unchanged. RSTN high mid-ACTIVE → M_GRANT = 0, ARB_BUSY = 0 after that edge.
